// File: rtl/seq_mult_gen_if.sv
// Request/result bundle between a controller (master) and the shared
// sequential multiplier (slave).
interface seq_mult_gen_if #(
  parameter int unsigned N = 4
);
  logic             start;
  logic             signed_mode;
  logic [N-1:0]     word1;
  logic [N-1:0]     word2;
  logic [2*N-1:0]   product;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output start, signed_mode, word1, word2,
    input  product, ready, busy, done
  );

  modport slave (
    input  start, signed_mode, word1, word2,
    output product, ready, busy, done
  );
endinterface

// File: rtl/seq_mult_gen.sv
// Radix-2 shift-add sequential multiplier, N iterations per product,
// run-time signed/unsigned selection, start/ready/done handshake.
module seq_mult_gen #(
  parameter int unsigned N = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_mult_gen_if.slave bus
);
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [N-1:0]     mcand;
  logic [N:0]       acc_hi;
  logic [N-1:0]     acc_lo;
  logic [CW-1:0]    cnt;
  logic             smode;
  logic [2*N-1:0]   product_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [N:0]       mcand_ext;
  logic [N:0]       addend;
  logic [N+1:0]     sum;
  logic             shift_in;
  logic [N:0]       nxt_hi;
  logic [N-1:0]     nxt_lo;

  // One iteration: conditional add (subtract on the signed MSB step), then shift.
  always_comb begin
    mcand_ext = smode ? {mcand[N-1], mcand} : {1'b0, mcand};
    addend    = '0;
    if (acc_lo[0]) begin
      addend = (smode && (cnt == '0)) ? (N+1)'(-mcand_ext) : mcand_ext;
    end
    sum      = {1'b0, acc_hi} + {1'b0, addend};
    shift_in = smode ? sum[N] : sum[N+1];
    nxt_hi   = {shift_in, sum[N:1]};
    nxt_lo   = {sum[0], acc_lo[N-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      smode     <= 1'b0;
      product_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand   <= bus.word1;
            acc_lo  <= bus.word2;
            smode   <= bus.signed_mode;
            acc_hi  <= '0;
            cnt     <= CW'(N - 1);
            state   <= CALC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == '0) begin
            // Low 2N bits of the shifted accumulator are the exact product.
            product_q <= {nxt_hi[N-1:0], nxt_lo};
            state     <= DONE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_mult_gen.sv
// Directed bench for seq_mult_gen (N=4) plus a model-checked N=8 sweep.
module tb_seq_mult_gen;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [7:0] last4;

  seq_mult_gen_if #(.N(4)) bus4 ();
  seq_mult_gen_if #(.N(8)) bus8 ();

  seq_mult_gen #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  seq_mult_gen #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full N=4 operation with cycle-exact handshake checks.
  task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input string tag);
    bus4.start = 1'b1; bus4.signed_mode = s; bus4.word1 = a; bus4.word2 = b;
    tick();
    bus4.start = 1'b0;
    bus4.word1 = ~a; bus4.word2 = ~b; bus4.signed_mode = ~s;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 64'(bus4.busy), 64'd1);
      chk({tag, "_nodone"}, 64'(bus4.done), 64'd0);
      chk({tag, "_hold"}, 64'(bus4.product), 64'(last4));
      if (i == 1) begin
        bus4.start = 1'b1;
        bus4.word1 = 4'h3;
      end else begin
        bus4.start = 1'b0;
      end
      tick();
    end
    bus4.start = 1'b0;
    chk({tag, "_done"}, 64'(bus4.done), 64'd1);
    chk({tag, "_prod"}, 64'(bus4.product), 64'(exp));
    chk({tag, "_ready"}, 64'(bus4.ready), 64'd1);
    tick();
    chk({tag, "_pulse"}, 64'(bus4.done), 64'd0);
    last4 = exp;
  endtask

  initial begin
    int lat;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] exp8;
    n_chk = 0; n_fail = 0; last4 = 8'h00;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.word1 = '0; bus4.word2 = '0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.word1 = '0; bus8.word2 = '0;
    #12;
    chk("rst_prod", 64'(bus4.product), 64'd0);
    chk("rst_ready", 64'(bus4.ready), 64'd1);
    chk("rst_busy", 64'(bus4.busy), 64'd0);
    chk("rst_done", 64'(bus4.done), 64'd0);
    chk("rst_ready8", 64'(bus8.ready), 64'd1);
    rst = 1'b0;
    tick();

    run4(1'b0, 4'hF, 4'hF, 8'hE1, "u_ff");
    for (int i = 0; i < 10; i++) tick();
    chk("u_ff_persist", 64'(bus4.product), 64'hE1);
    chk("u_ff_idle_ready", 64'(bus4.ready), 64'd1);

    run4(1'b1, 4'h8, 4'h7, 8'hC8, "s_m8x7");
    run4(1'b1, 4'h8, 4'h8, 8'h40, "s_m8xm8");
    run4(1'b1, 4'hF, 4'h1, 8'hFF, "s_m1x1");
    run4(1'b0, 4'h8, 4'h8, 8'h40, "u_8x8");
    run4(1'b0, 4'h8, 4'h7, 8'h38, "u_8x7");
    run4(1'b1, 4'h0, 4'h5, 8'h00, "s_0x5");
    run4(1'b0, 4'h7, 4'h0, 8'h00, "u_7x0");
    run4(1'b1, 4'h9, 4'h0, 8'h00, "s_m7x0");
    run4(1'b0, 4'h0, 4'hF, 8'h00, "u_0xf");
    run4(1'b1, 4'h7, 4'h9, 8'hCF, "s_7xm7");

    // Back-to-back with start held high, operands swapped in the DONE cycle.
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.word1 = 4'd3; bus4.word2 = 4'd5;
    tick();
    bus4.word1 = 4'd9; bus4.word2 = 4'd9;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_done1", 64'(bus4.done), 64'd1);
    chk("b2b_prod1", 64'(bus4.product), 64'd15);
    bus4.word1 = 4'd6; bus4.word2 = 4'd6;
    tick();
    chk("b2b_reaccept", 64'(bus4.busy), 64'd1);
    chk("b2b_hold15", 64'(bus4.product), 64'd15);
    bus4.word1 = 4'd1; bus4.word2 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_nodone", 64'(bus4.done), 64'd0);
      tick();
    end
    chk("b2b_nodone4", 64'(bus4.done), 64'd0);
    tick();
    chk("b2b_done2", 64'(bus4.done), 64'd1);
    chk("b2b_prod2", 64'(bus4.product), 64'd36);
    bus4.start = 1'b0;
    tick();
    chk("b2b_idle_ready", 64'(bus4.ready), 64'd1);
    chk("b2b_idle_done", 64'(bus4.done), 64'd0);
    last4 = 8'd36;

    // Asynchronous reset two cycles into CALC.
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.word1 = 4'd5; bus4.word2 = 4'd5;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_prod", 64'(bus4.product), 64'd0);
    chk("arst_ready", 64'(bus4.ready), 64'd1);
    chk("arst_busy", 64'(bus4.busy), 64'd0);
    chk("arst_done", 64'(bus4.done), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_nodone", 64'(bus4.done), 64'd0);
    end
    last4 = 8'd0;
    run4(1'b0, 4'd2, 4'd3, 8'd6, "arst_2x3");

    // N=8 sweep against a bench arithmetic model, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (k == 0) begin a8 = 8'h80; b8 = 8'h80; end
        if (k == 1) begin a8 = 8'hFF; b8 = 8'hFF; end
        if (m == 0) exp8 = {8'h00, a8} * {8'h00, b8};
        else        exp8 = {{8{a8[7]}}, a8} * {{8{b8[7]}}, b8};
        bus8.start = 1'b1; bus8.signed_mode = (m == 1); bus8.word1 = a8; bus8.word2 = b8;
        tick();
        bus8.start = 1'b0; bus8.word1 = 8'($urandom); bus8.word2 = 8'($urandom);
        lat = 0;
        while (!bus8.done && lat < 20) begin
          tick();
          lat++;
        end
        chk(m == 0 ? "n8u_lat" : "n8s_lat", 64'(lat), 64'd8);
        chk(m == 0 ? "n8u_prod" : "n8s_prod", 64'(bus8.product), 64'(exp8));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mult_gen.md
Name: seq_mult_gen

Overview:
Parametrised radix-2 shift-add sequential multiplier. It is the successor to the team's fixed 4-bit multiplier.
- Supports any operand width N ≥ 2.
- Supports run-time selection of signed (two's complement) or unsigned operation.
- Uses a start/ready/done handshake and holds a stable result register.
- Sits between a requesting controller and the datapath as a shared low-area multiply resource.

Parameters:
N, 4, operand width in bits; product is 2N bits.
CW, $clog2(N), width of the internal iteration counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only on a rising edge where ready=1
signed_mode  input  1  1 = two's complement operands, 0 = unsigned; sampled with start
word1  input  N  multiplicand; sampled with start
word2  input  N  multiplier; sampled with start
product  output  2N  result register; updated only at completion
ready  output  1  block can accept start this cycle
busy  output  1  multiplication in progress
done  output  1  one-cycle pulse: product just updated

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all internal registers cleared.
  - product=0, ready=1, busy=0, done=0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, DONE. ready=1 in IDLE and DONE; busy=1 in CALC only; done=1 in DONE only.
- Accept (IDLE or DONE, start=1 at an edge):
  - Latch word1, word2 and signed_mode.
  - Clear the accumulator; counter=N-1; go to CALC.
  - product is not modified at this edge.
- start=0 in DONE → IDLE. start=0 in IDLE → stay in IDLE.
- CALC: one iteration per cycle, N cycles total. Per iteration on mplr[0]:
  - Accumulator is N+1 bits upper part plus N bits lower part, sharing the multiplier register.
  - If mplr[0]=1, add the multiplicand to the upper part; on the final iteration in signed mode, subtract it instead (MSB weight is -2^(N-1)).
  - Then shift the whole accumulator right by 1. Shift-in is the sign of the upper part in signed mode, and the carry in unsigned mode.
  - Counter decrements each iteration.
  - At the edge where counter=0: load product with the exact 2N-bit result, go to DONE.
- Latency: acceptance at edge E0 → product valid and done=1 in the cycle after edge E0+N. Throughput is one result per N+1 cycles with back-to-back start.
- Arithmetic:
  - Unsigned: product = word1*word2, with no overflow (2N bits suffices).
  - Signed: product = exact two's complement product, including (-2^(N-1))*(-2^(N-1)) = +2^(2N-2).
- start while busy=1 is ignored: not queued, and operands are not re-sampled.
- Changes to word1/word2/signed_mode after acceptance have no effect.
- product holds its value indefinitely until the next completion.
- done is exactly one cycle per completed operation, never asserted twice for one operation.
- No X on any output after reset.

Test Plan:
1. N=4, unsigned, word1=4'hF, word2=4'hF, start pulse in IDLE → busy for 4 cycles; then done=1 for 1 cycle with product=8'hE1; ready=1; product still 8'hE1 ten cycles later.
2. N=4, signed: (-8)*7 → 8'hC8; (-8)*(-8) → 8'h40; (-1)*1 → 8'hFF. Repeat 4'h8*4'h8 unsigned → 8'h40. Repeat 4'h8*4'h7 unsigned → 8'h38.
3. N=4, 0*any and any*0 in both modes → product=0, done after 4 busy cycles. Previous nonzero product must remain visible until that done.
4. Back-to-back: hold start=1 with 3*5 unsigned, then change operands to 6*6 during the DONE cycle → product=15 with done, re-accept in the same cycle, product=36 with done exactly 5 cycles later. Operand changes and start pulses while busy have no effect.
5. Reset mid-operation: assert rst asynchronously 2 cycles into CALC → outputs immediately product=0, ready=1, busy=0, done=0. No done follows. A fresh 2*3 then yields 6.
6. N=8 randomised: 1000 random operand pairs in each mode, compared against a reference model → all exact. Latency is always 8 cycles from acceptance to done.
